// File: rtl/phi2_freq_meter.sv
// PHI2 frequency meter: synchronises the asynchronous PHI2 pin and counts its rising
// edges over a fixed gate window of GATE_CYCLES clk periods, publishing a held result.
module phi2_freq_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phi2,
    input  logic        restart,
    output logic [31:0] freq_out,
    output logic        freq_valid,
    output logic        phi2_present,
    output logic        measuring
);

    localparam int unsigned GW_GATE = $clog2(GATE_CYCLES);
    localparam int unsigned GW_SYNC = $clog2(SYNC_STAGES + 1);
    localparam int unsigned GW      = (GW_GATE > GW_SYNC) ? GW_GATE : GW_SYNC;

    localparam logic [GW-1:0] FLUSH_LAST = GW'(SYNC_STAGES);
    localparam logic [GW-1:0] GATE_LAST  = GW'(GATE_CYCLES - 1);

    typedef enum logic {
        S_FLUSH,
        S_MEASURE
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  gate_q, gate_d;
    logic [31:0]    edge_q, edge_d;
    logic [31:0]    edge_inc;
    logic           load;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], phi2};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

    // Saturating count including this cycle's edge; also the value published on the terminal cycle.
    assign edge_inc = (edge_q == '1) ? edge_q : edge_q + 32'(rise);

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        load    = 1'b0;
        case (state_q)
            S_FLUSH: begin
                edge_d = '0;
                if (gate_q == FLUSH_LAST) begin
                    state_d = S_MEASURE;
                    gate_d  = '0;
                end else begin
                    gate_d = gate_q + GW'(1);
                end
            end
            S_MEASURE: begin
                if (gate_q == GATE_LAST) begin
                    load   = 1'b1;
                    gate_d = '0;
                    edge_d = '0;
                end else begin
                    gate_d = gate_q + GW'(1);
                    edge_d = edge_inc;
                end
            end
            default: begin
                state_d = S_FLUSH;
                gate_d  = '0;
                edge_d  = '0;
            end
        endcase
        if (restart) begin
            state_d = S_FLUSH;
            gate_d  = '0;
            edge_d  = '0;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FLUSH;
            gate_q       <= '0;
            edge_q       <= '0;
            freq_out     <= '0;
            freq_valid   <= 1'b0;
            phi2_present <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_q     <= edge_d;
            freq_valid <= load;
            if (load) begin
                freq_out     <= edge_inc;
                phi2_present <= (edge_inc != '0);
            end
        end
    end

    assign measuring = (state_q == S_MEASURE);

endmodule

// File: tb/tb_phi2_freq_meter.sv
// Randomised scoreboard bench for phi2_freq_meter: a timestamp-based window model
// predicts each published count; a negedge monitor checks every DUT output.
module tb_phi2_freq_meter;

    localparam int GATE = 100;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phi2 = 1'b0;
    logic        restart = 1'b0;
    logic [31:0] freq_out;
    logic        freq_valid;
    logic        phi2_present;
    logic        measuring;

    phi2_freq_meter #(.GATE_CYCLES(GATE), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .phi2         (phi2),
        .restart      (restart),
        .freq_out     (freq_out),
        .freq_valid   (freq_valid),
        .phi2_present (phi2_present),
        .measuring    (measuring)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int      due;
        longint  freq;
        bit      present;
    } exp_t;
    exp_t sb[$];

    // PHI2 waveform source: period/high length may be changed at any time.
    int period = 10;
    int hi_len = 5;
    int ph = 0;
    always @(posedge clk) begin
        #1;
        phi2 = (ph < hi_len);
        ph = ph + 1;
        if (ph >= period) ph = 0;
    end

    // Reference model: a rise driven in cycle c is counted in cycle c+2; a window
    // starts 4 cycles after reset/restart and repeats every GATE cycles.
    int     win_start = 1 << 30;
    int     meas_from = 1 << 30;
    longint acc = 0;
    int     rise_q[$];
    bit     prev_phi2 = 1'b0;
    longint m_freq = 0;
    bit     m_present = 1'b0;
    int     t, e;
    exp_t   ent;

    always @(posedge clk) begin
        t = cyc;
        if (!rst_n) begin
            win_start = t + SYNC + 2;
            meas_from = t + SYNC + 2;
            acc = 0;
            rise_q.delete();
            prev_phi2 = 1'b0;
            m_freq = 0;
            m_present = 1'b0;
            sb.delete();
        end else begin
            if (phi2 && !prev_phi2) rise_q.push_back(t + SYNC);
            prev_phi2 = phi2;
            while (rise_q.size() > 0 && rise_q[0] <= t) begin
                e = rise_q.pop_front();
                if (e == t && t >= win_start) acc = acc + 1;
            end
            if (restart) begin
                win_start = t + SYNC + 2;
                meas_from = t + SYNC + 2;
                acc = 0;
            end else if (t == win_start + GATE - 1) begin
                if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
                ent.due = t + 1;
                ent.freq = acc;
                ent.present = (acc != 0);
                sb.push_back(ent);
                m_freq = acc;
                m_present = (acc != 0);
                acc = 0;
                win_start = win_start + GATE;
            end
        end
    end

    bit mon_en = 1'b0;
    exp_t got;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (measuring !== (cyc >= meas_from)) begin
                errors++;
                $display("FAIL measuring cyc=%0d got=%b exp=%b", cyc, measuring, (cyc >= meas_from));
            end
            while (sb.size() > 0 && sb[0].due < cyc) begin
                got = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_valid cyc=%0d got=none exp=valid@%0d freq=%0d", cyc, got.due, got.freq);
            end
            if (freq_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    errors++;
                    $display("FAIL spurious_valid cyc=%0d got=valid exp=no_valid", cyc);
                end else begin
                    got = sb.pop_front();
                    checks++;
                    if (freq_out !== got.freq[31:0]) begin
                        errors++;
                        $display("FAIL freq_out cyc=%0d got=%0d exp=%0d", cyc, freq_out, got.freq);
                    end
                    checks++;
                    if (phi2_present !== got.present) begin
                        errors++;
                        $display("FAIL present cyc=%0d got=%b exp=%b", cyc, phi2_present, got.present);
                    end
                end
            end
            checks++;
            if (freq_out !== m_freq[31:0] || phi2_present !== m_present) begin
                errors++;
                $display("FAIL hold cyc=%0d got=%0d/%b exp=%0d/%b",
                         cyc, freq_out, phi2_present, m_freq, m_present);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_phi2(input int p, input int h);
        period = p;
        hi_len = h;
        if (ph >= period) ph = 0;
    endtask

    task automatic wait_gate(input int g);
        int guard;
        guard = 0;
        while (!(cyc >= win_start && cyc == win_start + g) && guard < 3000) begin
            tick(1);
            guard++;
        end
        if (guard >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_gate got=timeout exp=gate_%0d", g);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tick(3);
        mon_en = 1'b1;
        checks++;
        if (freq_out !== 32'd0 || freq_valid !== 1'b0 || phi2_present !== 1'b0 || measuring !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=%0d/%b/%b/%b exp=0/0/0/0",
                     freq_out, freq_valid, phi2_present, measuring);
        end
        rst_n = 1'b1;

        set_phi2(10, 5);
        tick(350);

        set_phi2(10, 0);
        tick(330);

        set_phi2(4, 2);
        tick(320);

        set_phi2(10, 5);
        tick(150);
        wait_gate(50);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(250);

        wait_gate(70);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(250);

        wait_gate(40);
        set_phi2(5, 2);
        tick(350);

        wait_gate(GATE - 1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(250);

        repeat (10) begin
            int p;
            p = int'($urandom_range(4, 20));
            set_phi2(p, int'($urandom_range(2, p - 2)));
            tick(int'($urandom_range(50, 250)));
            if ($urandom_range(0, 3) == 0) begin
                restart = 1'b1;
                tick(1);
                restart = 1'b0;
            end
        end

        tick(230);
        checks++;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            errors++;
            $display("FAIL drain got=%0d_pending exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
